// File: rtl/sad_pkg.sv
// Shared definitions for the SAD block-accumulation stage: default operand
// width and block length, the pixel type and the accumulator width helper.
package sad_pkg;

  localparam int DATA_W_DEF  = 8;
  localparam int BLK_LEN_DEF = 16;

  typedef logic [DATA_W_DEF-1:0] pix_t;

  // Width able to hold blk_len maximum-valued operands without overflow.
  function automatic int acc_w(input int data_w, input int blk_len);
    return data_w + $clog2(blk_len);
  endfunction

endpackage

// File: rtl/abs_diff_unit.sv
// Exact combinational |a-b| on unsigned operands. Lives in its own module so
// an approximate abs-diff netlist can be dropped in without touching the
// accumulator.
module abs_diff_unit #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] d
);

  // Subtract the smaller operand from the larger so the result never wraps.
  always_comb begin
    if (a >= b) begin
      d = a - b;
    end else begin
      d = b - a;
    end
  end

endmodule

// File: rtl/sad_block_accum.sv
// Streaming SAD stage: accumulates |a-b| over BLK_LEN beats, tracks the
// per-block maximum and presents {sum, max} on a valid/ready port backed by a
// single result register.
// Optional build macro SAD_INPUT_PIPE_EN: inserts a register slot
// (diff, last flag, valid) between the abs-diff unit and the accumulator.
module sad_block_accum
  import sad_pkg::*;
#(
  parameter int    DATA_W  = DATA_W_DEF,
  parameter int    BLK_LEN = BLK_LEN_DEF,
  localparam int   ACC_W   = acc_w(DATA_W, BLK_LEN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sad,
  output logic [DATA_W-1:0] out_max
);

  localparam int              CNT_W    = $clog2(BLK_LEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLK_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [DATA_W-1:0] diff_s;
  logic              in_fire_s;
  logic              in_last_s;
  logic              in_ready_s;
  logic              res_block_s;
  logic              acc_fire_s;
  logic              acc_last_s;
  logic [DATA_W-1:0] acc_in_s;
  logic [ACC_W-1:0]  sum_new_s;
  logic [DATA_W-1:0] max_new_s;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [DATA_W-1:0] max_q, max_d;
  logic              out_valid_q, out_valid_d;
  logic [ACC_W-1:0]  sad_q, sad_d;
  logic [DATA_W-1:0] omax_q, omax_d;

  abs_diff_unit #(.DATA_W(DATA_W)) u_abs_diff (
    .a (in_a),
    .b (in_b),
    .d (diff_s)
  );

  // A pending result the consumer is not taking this cycle blocks a new load.
  assign res_block_s = out_valid_q & ~out_ready;
  assign in_last_s   = (cnt_q == LAST_CNT);
  assign in_fire_s   = in_valid & in_ready_s;

`ifdef SAD_INPUT_PIPE_EN
  logic              p_valid_q, p_valid_d;
  logic              p_last_q, p_last_d;
  logic [DATA_W-1:0] p_diff_q, p_diff_d;

  // Slot drains unless it holds a last beat that cannot reach the result register.
  always_comb begin
    in_ready_s = ~(p_valid_q & p_last_q & res_block_s);
    acc_fire_s = p_valid_q & ~(p_last_q & res_block_s);
    acc_last_s = p_last_q;
    acc_in_s   = p_diff_q;
  end

  // Pipe slot next state: load on accepted beat, empty when drained, else hold.
  always_comb begin
    p_valid_d = p_valid_q;
    p_last_d  = p_last_q;
    p_diff_d  = p_diff_q;
    if (in_fire_s) begin
      p_valid_d = 1'b1;
      p_last_d  = in_last_s;
      p_diff_d  = diff_s;
    end else if (acc_fire_s) begin
      p_valid_d = 1'b0;
    end else begin
      p_valid_d = p_valid_q;
    end
  end

  // Pipe slot registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_valid_q <= 1'b0;
      p_last_q  <= 1'b0;
      p_diff_q  <= {DATA_W{1'b0}};
    end else begin
      p_valid_q <= p_valid_d;
      p_last_q  <= p_last_d;
      p_diff_q  <= p_diff_d;
    end
  end
`else
  // Abs-diff feeds the accumulator directly; only a last beat needs the result slot.
  always_comb begin
    in_ready_s = ~(res_block_s & in_last_s);
    acc_fire_s = in_fire_s;
    acc_last_s = in_last_s;
    acc_in_s   = diff_s;
  end
`endif

  assign sum_new_s = acc_q + ACC_W'(acc_in_s);
  assign max_new_s = (acc_in_s > max_q) ? acc_in_s : max_q;

  // Beat counter on the input side; wraps to zero after the last beat.
  always_comb begin
    cnt_d = cnt_q;
    if (in_fire_s) begin
      if (in_last_s) begin
        cnt_d = {CNT_W{1'b0}};
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Accumulate, track max, and move the finished block into the result register.
  always_comb begin
    acc_d  = acc_q;
    max_d  = max_q;
    sad_d  = sad_q;
    omax_d = omax_q;
    if (acc_fire_s) begin
      if (acc_last_s) begin
        sad_d  = sum_new_s;
        omax_d = max_new_s;
        acc_d  = {ACC_W{1'b0}};
        max_d  = {DATA_W{1'b0}};
      end else begin
        acc_d  = sum_new_s;
        max_d  = max_new_s;
      end
    end else begin
      acc_d = acc_q;
    end
  end

  // Result valid: set on load, cleared on consume, a same-edge load wins.
  always_comb begin
    out_valid_d = out_valid_q;
    if (acc_fire_s & acc_last_s) begin
      out_valid_d = 1'b1;
    end else if (out_valid_q & out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Datapath and handshake state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q       <= {CNT_W{1'b0}};
      acc_q       <= {ACC_W{1'b0}};
      max_q       <= {DATA_W{1'b0}};
      out_valid_q <= 1'b0;
      sad_q       <= {ACC_W{1'b0}};
      omax_q      <= {DATA_W{1'b0}};
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      max_q       <= max_d;
      out_valid_q <= out_valid_d;
      sad_q       <= sad_d;
      omax_q      <= omax_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_q;
  assign out_sad   = sad_q;
  assign out_max   = omax_q;

endmodule

// File: tb/tb_sad_block_accum.sv
// Scoreboard bench for sad_block_accum (DATA_W=8, BLK_LEN=16). Expected
// results are queued when a block's last beat is accepted and compared while
// the DUT presents them. Honours SAD_INPUT_PIPE_EN for latency/stall points.
module tb_sad_block_accum;
  import sad_pkg::*;

  localparam int BL = 16;
`ifdef SAD_INPUT_PIPE_EN
  localparam int LAT      = 2;
  localparam int STALL_AT = 16;
`else
  localparam int LAT      = 1;
  localparam int STALL_AT = 15;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  pix_t        in_a;
  pix_t        in_b;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_sad;
  pix_t        out_max;

  typedef struct {
    int sad;
    int mx;
    int acc_cyc;
    bit chk_lat;
    bit seen;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   m_acc   = 0;
  int   m_max   = 0;
  int   m_cnt   = 0;
  bit   chk_lat = 1'b1;
  bit   chk_period = 1'b0;
  bit   have_prev  = 1'b0;
  int   prev_seen  = 0;
  int   results    = 0;
  logic [31:0] last_out_sad = 32'd0;
  logic [31:0] last_out_max = 32'd0;

  sad_block_accum dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sad   (out_sad),
    .out_max   (out_max)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used for latency and period measurement.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Output scoreboard check, then input-side reference model update.
  always @(negedge clk) begin
    int d;
    if (rst_n !== 1'b1) begin
      m_acc = 0;
      m_max = 0;
      m_cnt = 0;
      sb.delete();
    end else begin
      if (out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          chk("spurious_valid", {31'd0, out_valid}, 32'd0);
        end else begin
          chk("out_sad", {20'd0, out_sad}, sb[0].sad);
          chk("out_max", {24'd0, out_max}, sb[0].mx);
          if (!sb[0].seen) begin
            if (sb[0].chk_lat) chk("latency", cyc - sb[0].acc_cyc, LAT - 1);
            if (chk_period) begin
              if (have_prev) chk("period", cyc - prev_seen, BL);
              prev_seen = cyc;
              have_prev = 1'b1;
            end
            sb[0].seen = 1'b1;
          end
          if (out_ready === 1'b1) begin
            last_out_sad = {20'd0, out_sad};
            last_out_max = {24'd0, out_max};
            results++;
            void'(sb.pop_front());
          end
        end
      end
      if (in_valid === 1'b1 && in_ready === 1'b1) begin
        d = (in_a >= in_b) ? int'(in_a) - int'(in_b) : int'(in_b) - int'(in_a);
        m_acc += d;
        if (d > m_max) m_max = d;
        if (m_cnt == BL - 1) begin
          sb.push_back('{m_acc, m_max, cyc + 1, chk_lat, 1'b0});
          m_acc = 0;
          m_max = 0;
          m_cnt = 0;
        end else begin
          m_cnt++;
        end
      end
    end
  end

  // Present one beat from posedge+1 and hold it until accepted.
  task automatic send_beat(input int a, input int b, output bit stalled);
    in_valid = 1'b1;
    in_a = pix_t'(a);
    in_b = pix_t'(b);
    stalled = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        @(posedge clk);
        #1;
        return;
      end
      stalled = 1'b1;
    end
    chk("accept_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (sb.size() == 0 && out_valid !== 1'b1) break;
    end
    chk("drain_timeout", sb.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    in_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_out_sad"}, {20'd0, out_sad}, 32'd0);
    chk({tag, "_out_max"}, {24'd0, out_max}, 32'd0);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit st;
    int n;
    int r0;
    int stalls;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    do_reset("rst");

    // 1: uniform block
    for (int i = 0; i < BL; i++) send_beat(10, 3, st);
    in_valid = 1'b0;
    wait_drain();
    chk("t1_sad", last_out_sad, 32'd112);
    chk("t1_max", last_out_max, 32'd7);

    // 2: mixed order, symmetry of |a-b|
    send_beat(3, 10, st);
    send_beat(200, 0, st);
    for (int i = 2; i < BL; i++) send_beat(5, 5, st);
    in_valid = 1'b0;
    wait_drain();
    chk("t2_sad", last_out_sad, 32'd207);
    chk("t2_max", last_out_max, 32'd200);

    // 3: worst-case sum
    for (int i = 0; i < BL; i++) send_beat(255, 0, st);
    in_valid = 1'b0;
    wait_drain();
    chk("t3_sad", last_out_sad, 32'd4080);
    chk("t3_max", last_out_max, 32'd255);

    // 4: backpressure with the next block streaming
    chk_lat = 1'b0;
    r0 = results;
    out_ready = 1'b0;
    for (int i = 0; i < BL; i++) send_beat(i, 20, st);
    n = 0;
    for (int k = 0; k <= BL; k++) begin
      in_valid = 1'b1;
      in_a = (k < BL) ? pix_t'(k * 7) : pix_t'(1);
      in_b = pix_t'(50);
      @(negedge clk);
      if (in_ready !== 1'b1) break;
      @(posedge clk);
      #1;
      n++;
    end
    chk("t4_accepted", n, STALL_AT);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t4_stall", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int k = n; k < BL; k++) send_beat(k * 7, 50, st);
    in_valid = 1'b0;
    wait_drain();
    chk("t4_results", results - r0, 32'd2);
    chk_lat = 1'b1;

    // 5: continuous streaming over four blocks
    r0 = results;
    stalls = 0;
    have_prev = 1'b0;
    chk_period = 1'b1;
    for (int i = 0; i < 4 * BL; i++) begin
      send_beat($urandom_range(0, 255), $urandom_range(0, 255), st);
      stalls += int'(st);
    end
    in_valid = 1'b0;
    wait_drain();
    chk_period = 1'b0;
    chk("t5_bubbles", stalls, 32'd0);
    chk("t5_results", results - r0, 32'd4);

    // 6: reset mid-block, then a fresh block
    for (int i = 0; i < 7; i++) send_beat(50, 20, st);
    do_reset("t6_rst");
    for (int i = 0; i < BL; i++) send_beat(9, 4, st);
    in_valid = 1'b0;
    wait_drain();
    chk("t6_sad", last_out_sad, 32'd80);
    chk("t6_max", last_out_max, 32'd5);

    chk("end_queue_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
